id_ex_issue: RTL
================

Name: id_ex_issue

Overview:
- ID/EX pipeline register and operand-issue stage directly upstream of the ALU.
- Captures decoded instructions and register-file read data, and holds them across stalls.
- Inserts bubbles on flush or load-use hazards.
- Resolves data forwarding from the MEM and WB stages.
- Drives the ALU's opsel/sub/unsigned/arith/op1/op2 inputs plus EX-stage sideband: rd, wen, is_load, store data, pc.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, reset value of o_pc.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  decode holds a valid instruction.
- o_ready  out  1  stage accepts the decode instruction this cycle.
- i_pc  in  32  instruction address.
- i_rs1_addr, i_rs2_addr  in  5  source register indices.
- i_rs1_used, i_rs2_used  in  1  instruction reads rs1/rs2.
- i_rs1_data, i_rs2_data  in  32  register-file read data.
- i_imm  in  32  sign-extended immediate.
- i_op1_pc  in  1  op1 = pc instead of rs1.
- i_op2_imm  in  1  op2 = imm instead of rs2.
- i_opsel  in  3  ALU operation select.
- i_sub, i_unsigned, i_arith  in  1  ALU modifiers.
- i_rd_addr  in  5  destination register.
- i_rd_wen  in  1  writes rd.
- i_is_load  in  1  instruction is a load.
- i_stall  in  1  downstream hold request.
- i_flush  in  1  squash (branch/jump redirect).
- i_mem_wen  in  1  MEM-stage instruction writes rd.
- i_mem_rd  in  5  MEM-stage rd.
- i_mem_data  in  32  MEM-stage result.
- i_wb_wen  in  1  WB-stage instruction writes rd.
- i_wb_rd  in  5  WB-stage rd.
- i_wb_data  in  32  WB-stage result.
- o_valid  out  1  EX stage holds a valid instruction.
- o_alu_opsel  out  3  registered.
- o_alu_sub, o_alu_unsigned, o_alu_arith  out  1  registered.
- o_alu_op1, o_alu_op2  out  32  forwarded ALU operands.
- o_store_data  out  32  forwarded rs2.
- o_pc  out  32  registered.
- o_rd_addr  out  5  registered.
- o_rd_wen  out  1  registered; already gated by o_valid.
- o_is_load  out  1  registered; already gated by o_valid.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_valid=0, all control fields 0, o_pc=RESET_PC, captured data/rd/imm=0.
  - Outputs are valid immediately, with no clock required.
  - Reset asserted mid-stall or mid-hazard discards everything.
- Load-use hazard (combinational), true when all of the following hold:
  - o_valid & o_is_load & o_rd_wen & o_rd_addr!=0 & i_valid;
  - and either (i_rs1_used & i_rs1_addr==o_rd_addr) or (i_rs2_used & i_rs2_addr==o_rd_addr).
- o_ready = ~i_stall & ~hazard & ~i_flush.
- Per-edge update priority:
  - i_flush: o_valid<=0 and o_rd_wen/o_is_load<=0. Flush wins over stall and hazard.
  - else i_stall: all registers hold.
  - else hazard: o_valid<=0 (bubble); decode instruction is not consumed.
  - else i_valid: capture all fields, o_valid<=1.
  - else o_valid<=0.
- Bubble control state: o_rd_wen=0 and o_is_load=0. opsel and the data fields are don't-care, but must be deterministic.
- Capture-time write-through: when i_wb_wen & i_wb_rd!=0 & i_wb_rd==i_rsN_addr, capture i_wb_data instead of i_rsN_data. This covers the register file's same-cycle write.
- Output forwarding (combinational from registered rs values):
  - For each rsN: if MEM matches (i_mem_wen, rd!=0, rd==rsN) use i_mem_data; else if WB matches, use i_wb_data; else use the registered value.
  - MEM has priority over WB.
  - x0 is never forwarded; a captured x0 read is forced to 0.
- Operand selection:
  - o_alu_op1 = op1_pc ? o_pc : fwd_rs1.
  - o_alu_op2 = op2_imm ? imm : fwd_rs2.
  - o_store_data = fwd_rs2 always.
- Latency: one cycle from acceptance to o_valid.
- Throughput: one instruction per cycle absent stalls and hazards.
- A load-use hazard costs exactly one bubble.

Test Plan:
- Reset then ADD:
  - Stimulus: rs1_data=5, rs2_data=7, opsel=000, i_valid=1, no stall.
  - Response: next cycle o_valid=1, op1=5, op2=7, opsel=000. After reset, o_valid=0 and o_pc=RESET_PC.
- MEM forwarding:
  - Stimulus: captured rs1=x3 (regfile value 1), i_mem_wen=1, i_mem_rd=3, i_mem_data=0xDEAD_BEEF; WB also targets x3 with 0x1234.
  - Response: o_alu_op1=0xDEAD_BEEF.
- Load-use hazard:
  - Stimulus: EX holds a load to x5, decode ADD reads x5.
  - Response: o_ready=0 for one cycle, then bubble (o_valid=0, o_rd_wen=0). ADD is accepted the following cycle, o_valid=1.
- Stall vs flush:
  - Stimulus: i_stall=1 for 3 cycles.
  - Response: outputs are frozen and o_ready=0.
  - Stimulus: i_stall=1 and i_flush=1 together.
  - Response: next o_valid=0, o_rd_wen=0.
- Immediate/pc and x0:
  - Stimulus: op1_pc=1, op2_imm=1, pc=0x100, imm=0xFFFF_FFFC.
  - Response: op1=0x100, op2=0xFFFF_FFFC.
  - Stimulus: rs1=x0 with i_mem_rd=0, i_mem_wen=1, data=9.
  - Response: op1=0.
- Async reset mid-operation:
  - Stimulus: assert i_rst_n=0 between edges while o_valid=1.
  - Response: o_valid drops to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline register and operand-issue stage feeding the ALU.
//
// Captures decoded instruction fields and register-file read data. It holds
// them while the downstream stage stalls, and inserts a bubble on flush or on
// a load-use hazard. It resolves MEM/WB forwarding onto the issued operands.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid / o_ready        decode handshake
//   i_pc, i_rs*_*, i_imm     decoded instruction and register-file read data
//   i_op1_pc, i_op2_imm      operand source selects
//   i_opsel, i_sub,
//   i_unsigned, i_arith      ALU control
//   i_rd_addr, i_rd_wen,
//   i_is_load                destination / load sideband
//   i_stall, i_flush         pipeline hold / squash
//   i_mem_*, i_wb_*          forwarding sources from the MEM and WB stages
//   o_valid, o_alu_*         EX-stage valid and ALU inputs
//   o_store_data, o_pc,
//   o_rd_addr, o_rd_wen,
//   o_is_load                EX-stage sideband
module id_ex_issue #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic            i_rs1_used,
  input  logic            i_rs2_used,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_op1_pc,
  input  logic            i_op2_imm,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_wen,
  input  logic            i_is_load,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_mem_wen,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_wb_wen,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_valid,
  output logic [2:0]      o_alu_opsel,
  output logic            o_alu_sub,
  output logic            o_alu_unsigned,
  output logic            o_alu_arith,
  output logic [XLEN-1:0] o_alu_op1,
  output logic [XLEN-1:0] o_alu_op2,
  output logic [XLEN-1:0] o_store_data,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_wen,
  output logic            o_is_load
);

  // Pipeline state.
  logic            valid_r;
  logic [2:0]      opsel_r;
  logic            sub_r;
  logic            unsigned_r;
  logic            arith_r;
  logic [XLEN-1:0] pc_r;
  logic [4:0]      rd_addr_r;
  logic            rd_wen_r;
  logic            is_load_r;
  logic [4:0]      rs1_addr_r;
  logic [4:0]      rs2_addr_r;
  logic [XLEN-1:0] rs1_val_r;
  logic [XLEN-1:0] rs2_val_r;
  logic [XLEN-1:0] imm_r;
  logic            op1_pc_r;
  logic            op2_imm_r;

  logic            hazard_s;
  logic [XLEN-1:0] cap_rs1_s;
  logic [XLEN-1:0] cap_rs2_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;

  // Value to capture for a source register. x0 is always zero; a same-cycle
  // WB write is not yet visible in the register file read, so take it here.
  function automatic logic [XLEN-1:0] capture_val(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_wen,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] val;
    if (addr == 5'd0) begin
      val = '0;
    end else if (wb_wen && (wb_rd == addr)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Forwarded value of a captured source register; MEM is younger than WB,
  // so it wins. A zero address never matches because rd==0 is excluded.
  function automatic logic [XLEN-1:0] forward_val(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] reg_val,
    input logic            mem_wen,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_wen,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] val;
    if (mem_wen && (mem_rd != 5'd0) && (mem_rd == addr)) begin
      val = mem_data;
    end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == addr)) begin
      val = wb_data;
    end else begin
      val = reg_val;
    end
    return val;
  endfunction

  // Load-use hazard detection and decode handshake.
  always_comb begin
    hazard_s = valid_r & is_load_r & rd_wen_r & (rd_addr_r != 5'd0) & i_valid &
               ((i_rs1_used & (i_rs1_addr == rd_addr_r)) |
                (i_rs2_used & (i_rs2_addr == rd_addr_r)));
    o_ready  = ~i_stall & ~hazard_s & ~i_flush;
  end

  // Capture-time source values.
  always_comb begin
    cap_rs1_s = capture_val(i_rs1_addr, i_rs1_data, i_wb_wen, i_wb_rd, i_wb_data);
    cap_rs2_s = capture_val(i_rs2_addr, i_rs2_data, i_wb_wen, i_wb_rd, i_wb_data);
  end

  // Pipeline register update: flush > stall > hazard bubble > capture > idle.
  // Bubbles keep the data fields as they were, so they stay deterministic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r    <= 1'b0;
      opsel_r    <= 3'b000;
      sub_r      <= 1'b0;
      unsigned_r <= 1'b0;
      arith_r    <= 1'b0;
      pc_r       <= RESET_PC;
      rd_addr_r  <= 5'd0;
      rd_wen_r   <= 1'b0;
      is_load_r  <= 1'b0;
      rs1_addr_r <= 5'd0;
      rs2_addr_r <= 5'd0;
      rs1_val_r  <= '0;
      rs2_val_r  <= '0;
      imm_r      <= '0;
      op1_pc_r   <= 1'b0;
      op2_imm_r  <= 1'b0;
    end else if (i_flush) begin
      valid_r   <= 1'b0;
      rd_wen_r  <= 1'b0;
      is_load_r <= 1'b0;
    end else if (i_stall) begin
      valid_r <= valid_r;
    end else if (hazard_s || !i_valid) begin
      valid_r   <= 1'b0;
      rd_wen_r  <= 1'b0;
      is_load_r <= 1'b0;
    end else begin
      valid_r    <= 1'b1;
      opsel_r    <= i_opsel;
      sub_r      <= i_sub;
      unsigned_r <= i_unsigned;
      arith_r    <= i_arith;
      pc_r       <= i_pc;
      rd_addr_r  <= i_rd_addr;
      rd_wen_r   <= i_rd_wen;
      is_load_r  <= i_is_load;
      rs1_addr_r <= i_rs1_addr;
      rs2_addr_r <= i_rs2_addr;
      rs1_val_r  <= cap_rs1_s;
      rs2_val_r  <= cap_rs2_s;
      imm_r      <= i_imm;
      op1_pc_r   <= i_op1_pc;
      op2_imm_r  <= i_op2_imm;
    end
  end

  // Operand forwarding and selection.
  always_comb begin
    fwd_rs1_s = forward_val(rs1_addr_r, rs1_val_r, i_mem_wen, i_mem_rd, i_mem_data,
                            i_wb_wen, i_wb_rd, i_wb_data);
    fwd_rs2_s = forward_val(rs2_addr_r, rs2_val_r, i_mem_wen, i_mem_rd, i_mem_data,
                            i_wb_wen, i_wb_rd, i_wb_data);
    if (op1_pc_r) begin
      o_alu_op1 = pc_r;
    end else begin
      o_alu_op1 = fwd_rs1_s;
    end
    if (op2_imm_r) begin
      o_alu_op2 = imm_r;
    end else begin
      o_alu_op2 = fwd_rs2_s;
    end
    o_store_data = fwd_rs2_s;
  end

  assign o_valid        = valid_r;
  assign o_alu_opsel    = opsel_r;
  assign o_alu_sub      = sub_r;
  assign o_alu_unsigned = unsigned_r;
  assign o_alu_arith    = arith_r;
  assign o_pc           = pc_r;
  assign o_rd_addr      = rd_addr_r;
  assign o_rd_wen       = rd_wen_r;
  assign o_is_load      = is_load_r;

endmodule
